// File: rtl/adc_sample_conditioner_if.sv
// Stream bundle for the ADC sample conditioner: the sequencer response beats
// coming in and the conditioned sample stream going out.
interface adc_sample_conditioner_if #(
  parameter int DATA_W = 12,
  parameter int CH_W   = 5,
  parameter int OUT_W  = 16
);
  logic              response_valid;
  logic [CH_W-1:0]   response_channel;
  logic [DATA_W-1:0] response_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;

  // Conditioner side: consumes ADC beats, produces samples.
  modport slave (
    input  response_valid, response_channel, response_data, out_ready,
    output out_valid, out_data
  );

  // Environment side: drives ADC beats, consumes samples.
  modport master (
    output response_valid, response_channel, response_data, out_ready,
    input  out_valid, out_data
  );
endinterface

// File: rtl/adc_sample_conditioner.sv
// Channel select + boxcar decimation + DC removal/saturation + output FIFO
// for the ADC sequencer response stream, with sticky overflow and stale status.
module adc_sample_conditioner #(
  parameter int DATA_W      = 12,
  parameter int CH_W        = 5,
  parameter int AVG_LOG2    = 2,
  parameter int OUT_W       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          clock_clk,
  input  logic                          reset_sink_reset,
  input  logic                          enable,
  input  logic [CH_W-1:0]               sel_channel,
  input  logic [DATA_W-1:0]             dc_offset,
  input  logic                          clear_flags,
  adc_sample_conditioner_if.slave       bus,
  output logic                          overflow,
  output logic                          stale,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int SHIFT = OUT_W - DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic              match, chan_chg;
  logic [CH_W-1:0]   chan_q;
  logic [ACC_W-1:0]  acc, window_sum;
  logic [CNT_W-1:0]  cnt;
  logic              window_done;
  logic [DATA_W-1:0] mean, sat;
  logic signed [DATA_W:0] diff;
  logic [OUT_W-1:0]  conv_next, conv_data;
  logic              conv_vld;
  logic [OUT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              full, push, pop;

  assign match    = bus.response_valid & enable & (bus.response_channel == sel_channel);
  assign chan_chg = sel_channel != chan_q;

  // Remember last cycle's channel select so a change can flush the window.
  always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) chan_q <= '0;
    else                  chan_q <= sel_channel;
  end

  // Stage 1: accumulate matching beats; hand off the full sum and restart on the same edge.
  always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      acc         <= '0;
      cnt         <= '0;
      window_sum  <= '0;
      window_done <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (!enable || chan_chg) begin
        acc <= '0;
        cnt <= '0;
      end else if (match) begin
        if (cnt == CNT_LAST) begin
          window_sum  <= acc + ACC_W'(bus.response_data);
          window_done <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
        end else begin
          acc <= acc + ACC_W'(bus.response_data);
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign mean = DATA_W'(window_sum >> AVG_LOG2);
  assign diff = $signed({1'b0, mean}) - $signed({1'b0, dc_offset});

  // Clamp the one-bit-wider difference into the signed DATA_W range.
  always_comb begin
    sat = diff[DATA_W-1:0];
    if (diff[DATA_W] != diff[DATA_W-1])
      sat = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  // Left-justify; sign-extension bits are shifted out so only sat lands on top.
  assign conv_next = OUT_W'($signed(sat)) << SHIFT;

  // Stage 2: register the converted sample; it is pushed on the following edge.
  always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      conv_vld  <= 1'b0;
      conv_data <= '0;
    end else begin
      conv_vld <= window_done;
      if (window_done) conv_data <= conv_next;
    end
  end

  assign full          = level == LVL_W'(FIFO_DEPTH);
  assign pop           = bus.out_valid & bus.out_ready;
  assign push          = conv_vld & (!full | pop);
  assign bus.out_valid = level != '0;
  assign bus.out_data  = mem[rd_ptr];
  assign fifo_level    = level;

  // FIFO storage; cleared on reset so the head reads zero before any push.
  always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= conv_data;
    end
  end

  // FIFO pointers and occupancy; a pop frees the slot for a same-cycle push when full.
  always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset)               overflow <= 1'b0;
    else if (conv_vld && full && !pop)  overflow <= 1'b1;
    else if (clear_flags)               overflow <= 1'b0;
  end

  generate
    if (TIMEOUT_CYC > 0) begin : g_to
      logic [TO_W-1:0] to_cnt;
      // Cycles since the last matching beat, saturating at the timeout.
      always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset)                     to_cnt <= '0;
        else if (!enable || match)                to_cnt <= '0;
        else if (to_cnt != TO_W'(TIMEOUT_CYC))    to_cnt <= to_cnt + TO_W'(1);
      end
      assign stale = to_cnt == TO_W'(TIMEOUT_CYC);
    end else begin : g_no_to
      assign stale = 1'b0;
    end
  endgenerate
endmodule
